// File: rtl/pio_fifo.sv
// Host-side TX/RX FIFO pair for one state machine, sharing one 2*DEPTH storage array.
// The join configuration can hand the whole array to either direction.
module pio_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         join_tx,
    input  logic                         join_rx,
    input  logic                         flush,
    input  logic                         tx_wr,
    input  logic [31:0]                  tx_wdata,
    input  logic                         rx_rd,
    output logic [31:0]                  rx_rdata,
    input  logic                         mach_pull,
    output logic [31:0]                  mach_din,
    output logic                         mach_empty,
    input  logic                         mach_push,
    input  logic [31:0]                  mach_dout,
    output logic                         mach_full,
    output logic [$clog2(2*DEPTH):0]     tx_level,
    output logic [$clog2(2*DEPTH):0]     rx_level,
    output logic                         tx_full,
    output logic                         rx_empty,
    output logic [3:0]                   flags,
    input  logic [3:0]                   flags_clr
);
    localparam int N  = 2 * DEPTH;
    localparam int PW = $clog2(N);
    localparam int LW = PW + 1;
    typedef logic [LW-1:0] lvl_t;
    typedef logic [PW-1:0] ptr_t;

    logic [1:0]  join_q, join_d;
    ptr_t        tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    ptr_t        rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    lvl_t        tx_level_q, tx_level_d, rx_level_q, rx_level_d;
    logic [3:0]  flags_q, flags_d;
    logic [31:0] mem_q [N];
    logic [31:0] mem_d [N];

    lvl_t        tx_cap, rx_cap;
    ptr_t        rx_base;
    logic        tx_empty_i, tx_full_i, rx_empty_i, rx_full_i;
    logic        flush_all, tx_push, tx_pop, rx_push, rx_pop;
    logic [3:0]  flag_set;

    function automatic ptr_t ptr_inc(input ptr_t p, input lvl_t cap);
        lvl_t nxt;
        nxt = lvl_t'(p) + lvl_t'(1);
        return (nxt >= cap) ? '0 : nxt[PW-1:0];
    endfunction

    // Geometry follows the registered join bits; a change flushes on the same edge it is captured.
    always_comb begin
        tx_cap  = lvl_t'(DEPTH);
        rx_cap  = lvl_t'(DEPTH);
        rx_base = ptr_t'(DEPTH);
        if (join_q == 2'b10) begin
            tx_cap = lvl_t'(N);
            rx_cap = '0;
        end else if (join_q == 2'b01) begin
            tx_cap  = '0;
            rx_cap  = lvl_t'(N);
            rx_base = '0;
        end
    end

    assign tx_empty_i = (tx_level_q == '0);
    assign tx_full_i  = (tx_level_q == tx_cap);
    assign rx_empty_i = (rx_level_q == '0);
    assign rx_full_i  = (rx_level_q == rx_cap);

    assign mach_empty = tx_empty_i;
    assign tx_full    = tx_full_i;
    assign rx_empty   = rx_empty_i;
    assign mach_full  = rx_full_i;
    assign tx_level   = tx_level_q;
    assign rx_level   = rx_level_q;
    assign flags      = flags_q;
    assign mach_din   = tx_empty_i ? 32'd0 : mem_q[tx_rptr_q];
    assign rx_rdata   = rx_empty_i ? 32'd0 : mem_q[rx_base + rx_rptr_q];

    always_comb begin
        join_d     = {join_tx, join_rx};
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        tx_level_d = tx_level_q;
        rx_level_d = rx_level_q;
        mem_d      = mem_q;
        flush_all  = flush | (join_d != join_q);
        tx_push    = tx_wr & ~tx_full_i;
        tx_pop     = mach_pull & ~tx_empty_i;
        rx_push    = mach_push & ~rx_full_i;
        rx_pop     = rx_rd & ~rx_empty_i;
        flag_set   = {mach_push & rx_full_i, mach_pull & tx_empty_i,
                      rx_rd & rx_empty_i, tx_wr & tx_full_i};
        if (flush_all) begin
            tx_wptr_d  = '0;
            tx_rptr_d  = '0;
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            tx_level_d = '0;
            rx_level_d = '0;
            flag_set   = '0;
        end else begin
            if (tx_push) begin
                mem_d[tx_wptr_q] = tx_wdata;
                tx_wptr_d        = ptr_inc(tx_wptr_q, tx_cap);
            end
            if (tx_pop) tx_rptr_d = ptr_inc(tx_rptr_q, tx_cap);
            if (rx_push) begin
                mem_d[rx_base + rx_wptr_q] = mach_dout;
                rx_wptr_d                  = ptr_inc(rx_wptr_q, rx_cap);
            end
            if (rx_pop) rx_rptr_d = ptr_inc(rx_rptr_q, rx_cap);
            tx_level_d = tx_level_q + lvl_t'(tx_push) - lvl_t'(tx_pop);
            rx_level_d = rx_level_q + lvl_t'(rx_push) - lvl_t'(rx_pop);
        end
        // A new error event wins over a clear of the same bit.
        flags_d = (flags_q & ~flags_clr) | flag_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            join_q     <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_level_q <= '0;
            rx_level_q <= '0;
            flags_q    <= '0;
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else begin
            join_q     <= join_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_level_q <= tx_level_d;
            rx_level_q <= rx_level_d;
            flags_q    <= flags_d;
            for (int i = 0; i < N; i++) mem_q[i] <= mem_d[i];
        end
    end
endmodule

// File: tb/tb_pio_fifo.sv
// Directed bench for pio_fifo: reset, TX/RX paths, join, overflow/underflow flags, wrap, flush, reset.
module tb_pio_fifo;
    logic        clk = 1'b0;
    logic        reset, join_tx, join_rx, flush, tx_wr, rx_rd, mach_pull, mach_push;
    logic [31:0] tx_wdata, mach_dout, rx_rdata, mach_din;
    logic        mach_empty, mach_full, tx_full, rx_empty;
    logic [3:0]  tx_level, rx_level, flags, flags_clr;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pio_fifo #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .join_tx(join_tx), .join_rx(join_rx), .flush(flush),
        .tx_wr(tx_wr), .tx_wdata(tx_wdata), .rx_rd(rx_rd), .rx_rdata(rx_rdata),
        .mach_pull(mach_pull), .mach_din(mach_din), .mach_empty(mach_empty),
        .mach_push(mach_push), .mach_dout(mach_dout), .mach_full(mach_full),
        .tx_level(tx_level), .rx_level(rx_level), .tx_full(tx_full), .rx_empty(rx_empty),
        .flags(flags), .flags_clr(flags_clr)
    );

    // Advance one edge; outputs are then examined 1 ns after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; tx_wr = 0; rx_rd = 0; mach_pull = 0; mach_push = 0; flags_clr = 0;
        tx_wdata = 0; mach_dout = 0;
    endtask

    task automatic test_reset();
        reset = 1; join_tx = 0; join_rx = 0; idle();
        cycle(); cycle();
        reset = 0;
        cycle();
        tests_run++;
        if ({tx_level, rx_level, flags} !== 12'h000 || mach_empty !== 1 || rx_empty !== 1 ||
            tx_full !== 0 || mach_full !== 0 || rx_rdata !== 0 || mach_din !== 0) begin
            tests_failed++;
            $display("FAIL reset: lv=%0d/%0d flags=%h me=%b re=%b tf=%b mf=%b rd=%h din=%h",
                     tx_level, rx_level, flags, mach_empty, rx_empty, tx_full, mach_full, rx_rdata, mach_din);
        end
    endtask

    task automatic test_tx_basic();
        for (int i = 1; i <= 4; i++) begin
            tx_wr = 1; tx_wdata = i; cycle();
        end
        idle();
        tests_run++;
        if (tx_level !== 4 || tx_full !== 1 || mach_din !== 1) begin
            tests_failed++;
            $display("FAIL tx_fill: level=%0d full=%b din=%0d want 4 1 1", tx_level, tx_full, mach_din);
        end
        for (int i = 1; i <= 4; i++) begin
            tests_run++;
            if (mach_din !== i) begin
                tests_failed++;
                $display("FAIL tx_pull_data: got %0d want %0d", mach_din, i);
            end
            mach_pull = 1; cycle();
        end
        idle();
        tests_run++;
        if (mach_empty !== 1 || mach_din !== 0) begin
            tests_failed++;
            $display("FAIL tx_drained: empty=%b din=%h want 1 0", mach_empty, mach_din);
        end
    endtask

    task automatic test_overflow();
        for (int i = 21; i <= 24; i++) begin
            tx_wr = 1; tx_wdata = i; cycle();
        end
        tx_wr = 1; tx_wdata = 5; mach_pull = 1;
        cycle();
        idle();
        tests_run++;
        if (tx_level !== 3 || flags !== 4'b0001 || mach_din !== 22) begin
            tests_failed++;
            $display("FAIL tx_over: level=%0d flags=%b din=%0d want 3 0001 22", tx_level, flags, mach_din);
        end
        flags_clr = 4'b0001; cycle(); idle();
        tests_run++;
        if (flags !== 4'b0000) begin
            tests_failed++;
            $display("FAIL flags_clr: got %b want 0000", flags);
        end
        flush = 1; cycle(); idle();
        tests_run++;
        if (tx_level !== 0 || mach_empty !== 1) begin
            tests_failed++;
            $display("FAIL flush: level=%0d empty=%b want 0 1", tx_level, mach_empty);
        end
    endtask

    task automatic test_join_tx();
        join_tx = 1; cycle();
        for (int i = 10; i <= 17; i++) begin
            tests_run++;
            if (tx_full !== 0) begin
                tests_failed++;
                $display("FAIL join_tx_early_full: before write %0d full=%b", i, tx_full);
            end
            tx_wr = 1; tx_wdata = i; cycle();
        end
        idle();
        tests_run++;
        if (tx_full !== 1 || tx_level !== 8 || mach_full !== 1 || rx_empty !== 1) begin
            tests_failed++;
            $display("FAIL join_tx_full: tf=%b lvl=%0d mf=%b re=%b want 1 8 1 1", tx_full, tx_level, mach_full, rx_empty);
        end
        mach_push = 1; mach_dout = 99; cycle(); idle();
        tests_run++;
        if (flags !== 4'b1000 || rx_level !== 0) begin
            tests_failed++;
            $display("FAIL rx_stall: flags=%b rx_level=%0d want 1000 0", flags, rx_level);
        end
        for (int i = 10; i <= 17; i++) begin
            tests_run++;
            if (mach_din !== i) begin
                tests_failed++;
                $display("FAIL join_tx_order: got %0d want %0d", mach_din, i);
            end
            mach_pull = 1; cycle();
        end
        idle();
        flags_clr = 4'hF; join_tx = 0; cycle(); idle();
    endtask

    task automatic test_rx_under();
        mach_push = 1; mach_dout = 32'hA5; rx_rd = 1;
        cycle(); idle();
        tests_run++;
        if (flags !== 4'b0010 || rx_level !== 1 || rx_rdata !== 32'hA5) begin
            tests_failed++;
            $display("FAIL rx_under: flags=%b lvl=%0d rd=%h want 0010 1 a5", flags, rx_level, rx_rdata);
        end
        rx_rd = 1; flags_clr = 4'hF; cycle(); idle();
        tests_run++;
        if (rx_empty !== 1 || rx_rdata !== 0 || flags !== 0) begin
            tests_failed++;
            $display("FAIL rx_pop: empty=%b rd=%h flags=%b want 1 0 0000", rx_empty, rx_rdata, flags);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int errs;
        n = 100;
        errs = 0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            tx_wr = 1; tx_wdata = n; exp_q.push_back(n); n++; cycle();
        end
        idle();
        for (int i = 0; i < 10; i++) begin
            tx_wr = (i % 4 != 3);
            mach_pull = (i % 4 != 1);
            tx_wdata = n;
            if (mach_din !== exp_q[0] && mach_pull) errs++;
            if (tx_wr) begin
                exp_q.push_back(n); n++;
            end
            if (mach_pull) void'(exp_q.pop_front());
            cycle();
            tests_run++;
            if (tx_level !== exp_q.size()) begin
                tests_failed++;
                $display("FAIL wrap_level: step %0d got %0d want %0d", i, tx_level, exp_q.size());
            end
        end
        idle();
        while (exp_q.size() > 0) begin
            if (mach_din !== exp_q[0]) errs++;
            void'(exp_q.pop_front());
            mach_pull = 1; cycle();
        end
        idle();
        tests_run++;
        if (errs != 0 || mach_empty !== 1) begin
            tests_failed++;
            $display("FAIL wrap_order: %0d data errors, empty=%b want 0 1", errs, mach_empty);
        end
    endtask

    task automatic test_join_change_and_reset();
        mach_pull = 1; cycle(); idle();
        for (int i = 0; i < 2; i++) begin
            tx_wr = 1; tx_wdata = 50 + i; mach_push = 1; mach_dout = 60 + i; cycle();
        end
        idle();
        tests_run++;
        if (tx_level !== 2 || rx_level !== 2 || flags !== 4'b0100) begin
            tests_failed++;
            $display("FAIL pre_join: lv=%0d/%0d flags=%b want 2/2 0100", tx_level, rx_level, flags);
        end
        join_rx = 1; cycle();
        tests_run++;
        if (tx_level !== 0 || rx_level !== 0 || flags !== 4'b0100 || tx_full !== 1 || mach_empty !== 1) begin
            tests_failed++;
            $display("FAIL join_flush: lv=%0d/%0d flags=%b tf=%b me=%b want 0/0 0100 1 1",
                     tx_level, rx_level, flags, tx_full, mach_empty);
        end
        for (int i = 0; i < 2; i++) begin
            mach_push = 1; mach_dout = 70 + i; cycle();
        end
        idle();
        tests_run++;
        if (rx_level !== 2 || rx_rdata !== 70) begin
            tests_failed++;
            $display("FAIL join_rx_push: lvl=%0d rd=%0d want 2 70", rx_level, rx_rdata);
        end
        mach_push = 1; mach_dout = 72;
        #2 reset = 1;
        #1;
        tests_run++;
        if (rx_level !== 0 || flags !== 0 || rx_empty !== 1 || rx_rdata !== 0) begin
            tests_failed++;
            $display("FAIL async_reset: lvl=%0d flags=%b re=%b rd=%h want 0 0000 1 0", rx_level, flags, rx_empty, rx_rdata);
        end
        idle(); join_rx = 0;
        cycle();
        reset = 0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_overflow();
        test_join_tx();
        test_rx_under();
        test_back_to_back();
        test_join_change_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
